// File: rtl/mem_access_ctrl.sv
// MEM-stage access sequencer for the pipelined LC-3b: drives data-memory port b
// for word/byte loads and stores and the two-access indirect (LDI/STI) forms.
module mem_access_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [2:0]              req_op,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic                    done,
  output logic                    err,
  output logic [DATA_W-1:0]       rdata,
  output logic [ADDR_W-1:0]       mem_address,
  output logic                    mem_read_b,
  output logic                    mem_write_b,
  output logic [DATA_W/8-1:0]     mem_byte_enable_b,
  output logic [DATA_W-1:0]       mem_wdata_b,
  input  logic [DATA_W-1:0]       mem_rdata_b,
  input  logic                    mem_resp_b
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned LB    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TLIM  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [2:0] OP_LDW = 3'd0;
  localparam logic [2:0] OP_LDB = 3'd1;
  localparam logic [2:0] OP_STW = 3'd2;
  localparam logic [2:0] OP_STB = 3'd3;
  localparam logic [2:0] OP_LDI = 3'd4;
  localparam logic [2:0] OP_STI = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_GAP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                phase_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [TW-1:0]       tcnt_q;

  logic                op_legal;
  logic                word_op;
  logic                indirect;
  logic                is_wr;
  logic                timeout_hit;
  logic [LB-1:0]       lane;
  logic [7:0]          rdata_byte;
  logic [DATA_W-1:0]   load_data;
  logic [ADDR_W-1:0]   addr_word;
  logic [LANES-1:0]    be_onehot;
  logic [DATA_W-1:0]   wdata_rep;

  assign op_legal    = (req_op <= OP_STI);
  assign word_op     = !((op_q == OP_LDB) || (op_q == OP_STB));
  assign indirect    = (op_q == OP_LDI) || (op_q == OP_STI);
  assign is_wr       = (op_q == OP_STW) || (op_q == OP_STB) || ((op_q == OP_STI) && phase_q);
  assign timeout_hit = (TIMEOUT > 0) && (tcnt_q == TW'(TLIM));
  assign lane        = (LANES > 1) ? addr_q[LB-1:0] : '0;
  assign rdata_byte  = 8'(mem_rdata_b >> {lane, 3'b000});
  assign addr_word   = addr_q & ~ADDR_W'(LANES - 1);
  assign be_onehot   = LANES'(1) << lane;
  assign wdata_rep   = {LANES{wdata_q[7:0]}};

  // Final-access result; stores complete with zero.
  always_comb begin
    load_data = '0;
    case (op_q)
      OP_LDB:         load_data = DATA_W'(rdata_byte);
      OP_LDW, OP_LDI: load_data = mem_rdata_b;
      default:        load_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = op_legal ? S_ACC : S_DONE;
      S_ACC: begin
        // A response in the same cycle as the limit still completes normally.
        if (mem_resp_b)       state_d = (indirect && !phase_q) ? S_GAP : S_DONE;
        else if (timeout_hit) state_d = S_DONE;
      end
      S_GAP:   state_d = S_ACC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, pointer chase, result capture and per-access timeout count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= OP_LDW;
      addr_q  <= '0;
      wdata_q <= '0;
      phase_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            phase_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= !op_legal;
            tcnt_q  <= '0;
          end
        end
        S_ACC: begin
          if (mem_resp_b) begin
            if (indirect && !phase_q) begin
              addr_q  <= mem_rdata_b[ADDR_W-1:0];
              phase_q <= 1'b1;
            end else begin
              rdata_q <= load_data;
            end
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            tcnt_q <= TW'(tcnt_q + 1'b1);
          end
        end
        S_GAP:   tcnt_q <= '0;
        default: ;
      endcase
    end
  end

  // Moore decode of the registered state.
  always_comb begin
    req_ready         = 1'b0;
    done              = 1'b0;
    err               = 1'b0;
    rdata             = '0;
    mem_address       = '0;
    mem_read_b        = 1'b0;
    mem_write_b       = 1'b0;
    mem_byte_enable_b = '1;
    mem_wdata_b       = '0;
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_ACC: begin
        mem_address = word_op ? addr_word : addr_q;
        mem_read_b  = !is_wr;
        mem_write_b = is_wr;
        if (is_wr) begin
          mem_byte_enable_b = (op_q == OP_STB) ? be_onehot : '1;
          mem_wdata_b       = (op_q == OP_STB) ? wdata_rep : wdata_q;
        end
      end
      S_DONE: begin
        done  = 1'b1;
        err   = err_q;
        rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a responder checks each memory access
// against queued expectations and a monitor checks every completion.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        done;
  logic        err;
  logic [15:0] rdata;
  logic [15:0] mem_address;
  logic        mem_read_b;
  logic        mem_write_b;
  logic [1:0]  mem_byte_enable_b;
  logic [15:0] mem_wdata_b;
  logic [15:0] mem_rdata_b;
  logic        mem_resp_b;

  mem_access_ctrl #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .done(done), .err(err), .rdata(rdata),
    .mem_address(mem_address), .mem_read_b(mem_read_b), .mem_write_b(mem_write_b),
    .mem_byte_enable_b(mem_byte_enable_b), .mem_wdata_b(mem_wdata_b),
    .mem_rdata_b(mem_rdata_b), .mem_resp_b(mem_resp_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          delay;
    bit          follow;
  } acc_t;

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
  } res_t;

  acc_t exp_acc[$];
  res_t exp_res[$];
  logic [15:0] ref_mem [int];
  logic [15:0] phys_mem [int];
  int  n_checks = 0;
  int  n_errors = 0;
  int  accept_cyc = 0;
  bit  resp_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] dflt(input int w);
    return 16'((w * 37 + 3) & 16'h003F);
  endfunction

  function automatic logic [15:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : dflt(w);
  endfunction

  function automatic logic [15:0] phys_rd(input int w);
    return phys_mem.exists(w) ? phys_mem[w] : dflt(w);
  endfunction

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    ref_mem[int'(a >> 1)]  = v;
    phys_mem[int'(a >> 1)] = v;
  endtask

  function automatic int lat_of(input int d);
    return (d >= TO) ? TO : d + 1;
  endfunction

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    return (r < 8) ? (r % 4) : (TO + r - 8);
  endfunction

  task automatic push_acc(input logic [15:0] a, input logic wr, input logic [15:0] wd,
                          input logic [1:0] be, input int d, input bit follow);
    acc_t e;
    e.addr = a; e.wr = wr; e.wdata = wd; e.be = be; e.delay = d; e.follow = follow;
    exp_acc.push_back(e);
  endtask

  // Reference behaviour of one request, then drive it and wait for completion.
  task automatic issue(input logic [2:0] op, input logic [15:0] addr,
                       input logic [15:0] wdata, input int d0, input int d1);
    res_t r;
    int w, budget;
    logic [15:0] ptr, cur, wa;
    bit ok0;
    r.err = 1'b0; r.rdata = 16'h0; r.lat = 0;
    w   = int'(addr >> 1);
    wa  = addr & 16'hFFFE;
    ok0 = (d0 < TO);
    case (op)
      3'd0: begin
        push_acc(wa, 1'b0, 16'h0, 2'b11, d0, 1'b0);
        if (ok0) r.rdata = ref_rd(w); else r.err = 1'b1;
        r.lat = lat_of(d0);
      end
      3'd1: begin
        push_acc(addr, 1'b0, 16'h0, 2'b11, d0, 1'b0);
        cur = ref_rd(w);
        if (ok0) r.rdata = addr[0] ? {8'h00, cur[15:8]} : {8'h00, cur[7:0]};
        else r.err = 1'b1;
        r.lat = lat_of(d0);
      end
      3'd2: begin
        push_acc(wa, 1'b1, wdata, 2'b11, d0, 1'b0);
        if (ok0) ref_mem[w] = wdata; else r.err = 1'b1;
        r.lat = lat_of(d0);
      end
      3'd3: begin
        push_acc(addr, 1'b1, {wdata[7:0], wdata[7:0]}, addr[0] ? 2'b10 : 2'b01, d0, 1'b0);
        if (ok0) begin
          cur = ref_rd(w);
          if (addr[0]) cur[15:8] = wdata[7:0]; else cur[7:0] = wdata[7:0];
          ref_mem[w] = cur;
        end else r.err = 1'b1;
        r.lat = lat_of(d0);
      end
      3'd4, 3'd5: begin
        push_acc(wa, 1'b0, 16'h0, 2'b11, d0, ok0);
        r.lat = lat_of(d0);
        if (!ok0) r.err = 1'b1;
        else begin
          ptr = ref_rd(w) & 16'hFFFE;
          push_acc(ptr, op == 3'd5, wdata, 2'b11, d1, 1'b0);
          r.lat = r.lat + 1 + lat_of(d1);
          if (d1 >= TO) r.err = 1'b1;
          else if (op == 3'd4) r.rdata = ref_rd(int'(ptr >> 1));
          else ref_mem[int'(ptr >> 1)] = wdata;
        end
      end
      default: r.err = 1'b1;
    endcase
    exp_res.push_back(r);

    @(negedge clk);
    check("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    accept_cyc = cyc;
    check("ready_busy", req_ready, 0);
    budget = 0;
    forever begin
      @(negedge clk);
      if (done) begin req_valid = 1'b0; break; end
      budget++;
      if (budget > 100) begin
        check("done_timeout", 0, 1);
        req_valid = 1'b0;
        exp_res.delete();
        exp_acc.delete();
        break;
      end
      // Requests offered while busy must be ignored.
      req_valid = 1'($urandom_range(0, 1));
      req_op    = 3'($urandom_range(0, 7));
      req_addr  = 16'($urandom);
    end
  endtask

  // Memory responder: checks an access against its expectation and replies.
  task automatic serve(output bit follow);
    acc_t e;
    logic [15:0] a0;
    logic rd0, wr0;
    int n;
    follow = 1'b0;
    a0 = mem_address; rd0 = mem_read_b; wr0 = mem_write_b;
    if (exp_acc.size() == 0) begin
      check("unexpected_access", {rd0, wr0}, 2'b00);
      return;
    end
    e = exp_acc.pop_front();
    check("acc_addr", a0, e.addr);
    check("acc_strobes", {rd0, wr0}, {!e.wr, e.wr});
    if (e.wr) begin
      check("acc_wdata", mem_wdata_b, e.wdata);
      check("acc_be", mem_byte_enable_b, e.be);
    end
    n = 1;
    forever begin
      if (n == e.delay + 1) begin
        mem_resp_b  = 1'b1;
        mem_rdata_b = phys_rd(int'(a0 >> 1));
        if (wr0) begin
          for (int b = 0; b < 2; b++)
            if (mem_byte_enable_b[b]) mem_rdata_b[b*8 +: 8] = mem_wdata_b[b*8 +: 8];
          phys_mem[int'(a0 >> 1)] = mem_rdata_b;
        end
        @(negedge clk);
        mem_resp_b  = 1'b0;
        mem_rdata_b = 16'($urandom);
        check("strobes_drop", {mem_read_b, mem_write_b}, 2'b00);
        follow = e.follow;
        return;
      end
      @(negedge clk);
      if (!(mem_read_b || mem_write_b)) break;
      check("strobe_hold", {mem_address, mem_read_b, mem_write_b}, {a0, rd0, wr0});
      n++;
      if (n > 50) break;
    end
    check("timeout_cycles", 64'(n), 64'(TO));
  endtask

  initial begin : responder
    bit expect_follow;
    expect_follow = 1'b0;
    mem_resp_b  = 1'b0;
    mem_rdata_b = 16'h0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        expect_follow = 1'b0;
      end else begin
        if (expect_follow) begin
          check("gap_one_cycle", mem_read_b || mem_write_b, 1);
          expect_follow = 1'b0;
        end
        if (mem_read_b || mem_write_b) serve(expect_follow);
      end
    end
  end

  initial begin : monitor
    res_t r;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && done) begin
        if (exp_res.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          r = exp_res.pop_front();
          check("err", err, r.err);
          check("rdata", rdata, r.rdata);
          check("latency", 64'(cyc - accept_cyc), 64'(r.lat));
        end
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_addr = 16'h0; req_wdata = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_ready", req_ready, 1);
    check("rst_done_err", {done, err}, 2'b00);
    check("rst_rdata", rdata, 0);
    check("rst_strobes", {mem_read_b, mem_write_b}, 2'b00);
    check("rst_be", mem_byte_enable_b, 2'b11);
    check("rst_addr", mem_address, 0);

    poke(16'h1234, 16'hBEEF);
    issue(3'd0, 16'h1235, 16'h0, 3, 0);
    poke(16'h2000, 16'hA55A);
    issue(3'd1, 16'h2001, 16'h0, 1, 0);
    issue(3'd1, 16'h2000, 16'h0, 0, 0);
    issue(3'd3, 16'h3001, 16'h0077, 2, 0);
    poke(16'h0100, 16'h4000);
    poke(16'h4000, 16'h1111);
    issue(3'd4, 16'h0100, 16'h0, 0, 1);
    issue(3'd5, 16'h0100, 16'h5555, 1, 2);
    issue(3'd0, 16'h4000, 16'h0, 0, 0);
    issue(3'd7, 16'h0000, 16'h0, 0, 0);
    issue(3'd6, 16'h0002, 16'h0, 0, 0);
    issue(3'd0, 16'h0010, 16'h0, 5, 0);
    issue(3'd5, 16'h0020, 16'hABCD, 0, 6);

    // Reset in the middle of an access; a late response must not complete it.
    resp_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_addr = 16'h0042;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_read", mem_read_b, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_strobes", {mem_read_b, mem_write_b}, 2'b00);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_be", mem_byte_enable_b, 2'b11);
    @(negedge clk);
    rst_n = 1'b1;
    mem_resp_b = 1'b1; mem_rdata_b = 16'hDEAD;
    @(negedge clk);
    mem_resp_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("late_resp_no_done", done, 0);
      @(negedge clk);
    end
    check("late_resp_idle", {req_ready, mem_read_b, mem_write_b}, 3'b100);
    resp_en = 1'b1;

    for (int i = 0; i < 200; i++)
      issue(3'($urandom_range(0, 7)), 16'($urandom_range(0, 63)), 16'($urandom),
            pick_delay(), pick_delay());

    repeat (5) @(negedge clk);
    check("acc_queue_empty", 64'(exp_acc.size()), 0);
    check("res_queue_empty", 64'(exp_res.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
